// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control constants: hold encodings, controller state codes
// and the default divider timeout.
package hazard_ctrl_pkg;

    typedef enum logic [2:0] {
        Hold_None = 3'd0,
        Hold_Pc   = 3'd1,
        Hold_If   = 3'd2,
        Hold_Id   = 3'd3
    } hold_e;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_DIV_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;
    localparam logic [1:0] ST_HALT     = 2'd3;

    localparam int DIV_TIMEOUT_DEF = 40;

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: arbitrates halt, interrupt and branch redirects,
// divider stalls and memory/load-use holds, and counts stalled cycles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF,
    parameter int STALL_CW    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                halt_req_i,
    input  logic                int_assert_i,
    input  logic [31:0]         int_addr_i,
    input  logic                ex_jump_flag_i,
    input  logic [31:0]         ex_jump_addr_i,
    input  logic                div_start_i,
    input  logic                div_ready_i,
    input  logic                bus_hold_i,
    input  logic                id_hold_i,
    input  logic                cnt_clr_i,
    output logic [2:0]          hold_flag_o,
    output logic                jump_flag_o,
    output logic [31:0]         jump_addr_o,
    output logic                flush_o,
    output logic                div_err_o,
    output logic [STALL_CW-1:0] stall_cnt_o,
    output logic [1:0]          state_o
);

    localparam int TCW = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT + 1) : 1;

    logic [1:0]          state_reg, state_next;
    logic [TCW-1:0]      tmo_reg, tmo_next;
    logic                flush_reg;
    logic                div_err_reg, div_err_next;
    logic [STALL_CW-1:0] stall_cnt_reg;
    hold_e               hold;
    logic                jump;
    logic [31:0]         jump_addr;

    always_comb begin
        state_next   = state_reg;
        tmo_next     = tmo_reg;
        div_err_next = 1'b0;
        hold         = Hold_None;
        jump         = 1'b0;
        jump_addr    = 32'd0;
        case (state_reg)
            ST_RUN: begin
                if (halt_req_i) begin
                    hold       = Hold_Id;
                    state_next = ST_HALT;
                end else if (int_assert_i) begin
                    jump       = 1'b1;
                    jump_addr  = int_addr_i;
                    state_next = ST_FLUSH;
                end else if (ex_jump_flag_i) begin
                    jump       = 1'b1;
                    jump_addr  = ex_jump_addr_i;
                    state_next = ST_FLUSH;
                end else if (div_start_i) begin
                    hold       = Hold_Id;
                    tmo_next   = '0;
                    state_next = ST_DIV_WAIT;
                end else if (id_hold_i) begin
                    hold = Hold_Id;
                end else if (bus_hold_i) begin
                    hold = Hold_Pc;
                end
            end
            ST_DIV_WAIT: begin
                // Halt and interrupts are deliberately not looked at here;
                // a pending halt is picked up from RUN after the divide ends.
                if (div_ready_i) begin
                    if (ex_jump_flag_i) begin
                        jump       = 1'b1;
                        jump_addr  = ex_jump_addr_i;
                        state_next = ST_FLUSH;
                    end else begin
                        state_next = ST_RUN;
                    end
                end else begin
                    hold = Hold_Id;
                    if (tmo_reg == TCW'(DIV_TIMEOUT - 1)) begin
                        div_err_next = 1'b1;
                        state_next   = ST_RUN;
                    end else begin
                        tmo_next = tmo_reg + TCW'(1);
                    end
                end
            end
            ST_FLUSH: begin
                state_next = halt_req_i ? ST_HALT : ST_RUN;
            end
            ST_HALT: begin
                hold = Hold_Id;
                if (!halt_req_i) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_RUN;
            tmo_reg       <= '0;
            flush_reg     <= 1'b0;
            div_err_reg   <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            tmo_reg     <= tmo_next;
            flush_reg   <= (state_next == ST_FLUSH);
            div_err_reg <= div_err_next;
            if (cnt_clr_i) begin
                stall_cnt_reg <= '0;
            end else if ((hold != Hold_None) && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + STALL_CW'(1);
            end
        end
    end

    assign hold_flag_o = hold;
    assign jump_flag_o = jump;
    assign jump_addr_o = jump_addr;
    assign flush_o     = flush_reg;
    assign div_err_o   = div_err_reg;
    assign stall_cnt_o = stall_cnt_reg;
    assign state_o     = state_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int DIV_TIMEOUT = 40;
    localparam int STALL_CW    = 6;
    localparam int STALL_MAX   = (1 << STALL_CW) - 1;

    localparam int M_RUN = 0, M_DIV = 1, M_FLUSH = 2, M_HALT = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                halt_req, int_assert, ex_jump_flag, div_start, div_ready;
    logic                bus_hold, id_hold, cnt_clr;
    logic [31:0]         int_addr, ex_jump_addr;
    logic [2:0]          hold_flag;
    logic                jump_flag, flush, div_err;
    logic [31:0]         jump_addr;
    logic [STALL_CW-1:0] stall_cnt;
    logic [1:0]          state;

    always #5 clk = ~clk;

    hazard_ctrl #(.DIV_TIMEOUT(DIV_TIMEOUT), .STALL_CW(STALL_CW)) dut (
        .clk(clk), .rst(rst),
        .halt_req_i(halt_req), .int_assert_i(int_assert), .int_addr_i(int_addr),
        .ex_jump_flag_i(ex_jump_flag), .ex_jump_addr_i(ex_jump_addr),
        .div_start_i(div_start), .div_ready_i(div_ready),
        .bus_hold_i(bus_hold), .id_hold_i(id_hold), .cnt_clr_i(cnt_clr),
        .hold_flag_o(hold_flag), .jump_flag_o(jump_flag), .jump_addr_o(jump_addr),
        .flush_o(flush), .div_err_o(div_err), .stall_cnt_o(stall_cnt), .state_o(state)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int n_cycle  = 0;

    // Reference model: mode, divider cycles already waited, pending error, stall total
    int m_mode, m_waited, m_stall;
    bit m_err;

    // Observation tallies used for whole-scenario checks
    int obs_h3, obs_err;

    task chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, n_cycle, obs, exp);
        end
    endtask

    task clear_inputs();
        halt_req = 0; int_assert = 0; ex_jump_flag = 0; div_start = 0; div_ready = 0;
        bus_hold = 0; id_hold = 0; cnt_clr = 0; int_addr = 0; ex_jump_addr = 0;
    endtask

    task model_reset();
        m_mode = M_RUN; m_waited = 0; m_err = 0; m_stall = 0;
    endtask

    // Called just after a falling edge with inputs already applied
    task do_cycle();
        int  e_hold, nxt;
        bit  e_jmp, nxt_err;
        logic [31:0] e_addr;
        e_hold = 0; e_jmp = 0; e_addr = 0; nxt = m_mode; nxt_err = 0;
        #1;
        case (m_mode)
            M_RUN: begin
                if (halt_req)          begin e_hold = 3; nxt = M_HALT; end
                else if (int_assert)   begin e_jmp = 1; e_addr = int_addr; nxt = M_FLUSH; end
                else if (ex_jump_flag) begin e_jmp = 1; e_addr = ex_jump_addr; nxt = M_FLUSH; end
                else if (div_start)    begin e_hold = 3; nxt = M_DIV; end
                else                   e_hold = id_hold ? 3 : (bus_hold ? 1 : 0);
            end
            M_DIV: begin
                if (div_ready) begin
                    if (ex_jump_flag) begin e_jmp = 1; e_addr = ex_jump_addr; nxt = M_FLUSH; end
                    else nxt = M_RUN;
                end else begin
                    e_hold = 3;
                    if (m_waited + 1 >= DIV_TIMEOUT) begin nxt_err = 1; nxt = M_RUN; end
                end
            end
            M_FLUSH: nxt = halt_req ? M_HALT : M_RUN;
            default: begin e_hold = 3; if (!halt_req) nxt = M_RUN; end
        endcase
        chk("hold_flag", 64'(hold_flag), 64'(e_hold));
        chk("jump_flag", 64'(jump_flag), 64'(e_jmp));
        chk("jump_addr", 64'(jump_addr), 64'(e_addr));
        chk("flush",     64'(flush),     64'(m_mode == M_FLUSH));
        chk("div_err",   64'(div_err),   64'(m_err));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk("state",     64'(state),     64'(m_mode));
        if (hold_flag == 3'd3) obs_h3++;
        if (div_err) obs_err++;
        @(posedge clk);
        m_waited = (nxt == M_DIV && m_mode == M_DIV) ? m_waited + 1 : 0;
        m_stall  = cnt_clr ? 0 : ((e_hold != 0 && m_stall < STALL_MAX) ? m_stall + 1 : m_stall);
        m_err    = nxt_err;
        m_mode   = nxt;
        n_cycle++;
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between clock edges; outputs checked before any edge
    task apply_reset();
        clear_inputs();
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_state",   64'(state),     64'(M_RUN));
        chk("rst_flush",   64'(flush),     64'd0);
        chk("rst_div_err", 64'(div_err),   64'd0);
        chk("rst_stall",   64'(stall_cnt), 64'd0);
        chk("rst_hold",    64'(hold_flag), 64'd0);
        chk("rst_jump",    64'(jump_flag), 64'd0);
        chk("rst_addr",    64'(jump_addr), 64'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        obs_h3 = 0; obs_err = 0;
        @(negedge clk);
        apply_reset();

        // Branch taken in RUN, then the flush cycle, then back to RUN
        ex_jump_flag = 1; ex_jump_addr = 32'h0000_0100;
        do_cycle();
        clear_inputs();
        do_cycle();
        do_cycle();

        // Interrupt wins over a simultaneous branch
        int_assert = 1; int_addr = 32'h8; ex_jump_flag = 1; ex_jump_addr = 32'h100;
        do_cycle();
        clear_inputs();
        do_cycle();

        // Divide that completes after 33 wait cycles
        cnt_clr = 1; do_cycle(); cnt_clr = 0;
        obs_h3 = 0; obs_err = 0;
        div_start = 1; do_cycle(); div_start = 0;
        repeat (33) do_cycle();
        div_ready = 1; do_cycle(); div_ready = 0;
        do_cycle();
        chk("div_ok_hold_cycles", 64'(obs_h3), 64'd34);
        chk("div_ok_err_count",   64'(obs_err), 64'd0);
        chk("div_ok_stall",       64'(stall_cnt), 64'd34);

        // Divide that never completes
        cnt_clr = 1; do_cycle(); cnt_clr = 0;
        obs_h3 = 0; obs_err = 0;
        div_start = 1; do_cycle(); div_start = 0;
        repeat (DIV_TIMEOUT + 5) do_cycle();
        chk("div_tmo_err_count", 64'(obs_err), 64'd1);
        chk("div_tmo_state",     64'(state), 64'(M_RUN));
        chk("div_tmo_stall",     64'(stall_cnt), 64'd41);

        // Bus and load-use hold together
        cnt_clr = 1; do_cycle(); cnt_clr = 0;
        bus_hold = 1; id_hold = 1;
        repeat (5) do_cycle();
        clear_inputs();
        do_cycle();
        chk("both_hold_stall", 64'(stall_cnt), 64'd5);
        cnt_clr = 1; do_cycle(); cnt_clr = 0;
        chk("stall_cleared", 64'(stall_cnt), 64'd0);
        bus_hold = 1; do_cycle(); clear_inputs();

        // Counter saturation
        id_hold = 1;
        repeat (STALL_MAX + 8) do_cycle();
        clear_inputs();
        do_cycle();
        chk("stall_saturated", 64'(stall_cnt), 64'(STALL_MAX));

        // Halt requested during a divide is taken only after the divide ends
        div_start = 1; do_cycle(); div_start = 0;
        repeat (3) do_cycle();
        halt_req = 1;
        repeat (4) do_cycle();
        chk("halt_in_div_state", 64'(state), 64'(M_DIV));
        div_ready = 1; do_cycle(); div_ready = 0;
        repeat (2) do_cycle();
        chk("halt_after_div", 64'(state), 64'(M_HALT));
        apply_reset();
        do_cycle();

        // Reset in the middle of a divide and in the middle of a flush
        div_start = 1; do_cycle(); div_start = 0;
        repeat (10) do_cycle();
        apply_reset();
        repeat (DIV_TIMEOUT + 2) do_cycle();
        ex_jump_flag = 1; ex_jump_addr = 32'hDEAD_BEE0; do_cycle(); clear_inputs();
        apply_reset();
        do_cycle();

        // Random traffic
        repeat (3000) begin
            halt_req     = ($urandom_range(0, 29) == 0) ? 1'b1 : (halt_req && $urandom_range(0, 3) != 0);
            int_assert   = ($urandom_range(0, 19) == 0);
            int_addr     = $urandom;
            ex_jump_flag = ($urandom_range(0, 7) == 0);
            ex_jump_addr = $urandom;
            div_start    = ($urandom_range(0, 9) == 0);
            div_ready    = ($urandom_range(0, 24) == 0);
            bus_hold     = ($urandom_range(0, 3) == 0);
            id_hold      = ($urandom_range(0, 4) == 0);
            cnt_clr      = ($urandom_range(0, 49) == 0);
            do_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
